// File: rtl/psec5_ch_digital.sv
// psec5_ch_digital: per-channel digital back end of the PSEC5 sampler.
// The channel arms on INST_START and accepts one stop (a discriminator hit
// and/or INST_STOP, chosen by MODE). After TRIG_DELAY cycles it raises the
// segment stops TRIGGERA..E one per cycle and latches the coarse counters
// CA..CE at those edges. Latched words are shifted out MSB first on CNT_SER,
// paced by the synchronised SPI_CLK and gated by LOAD_CNT_SER.
module psec5_ch_digital #(
    parameter int CNT_W = 10,
    parameter int DLY_W = 5
) (
    input  logic             FCLK,
    input  logic             RST,
    input  logic             INST_START,
    input  logic             INST_STOP,
    input  logic             INST_READOUT,
    input  logic             DISCRIMINATOR_OUTPUT,
    input  logic             DISCRIMINATOR_POLARITY,
    input  logic [1:0]       MODE,
    input  logic [DLY_W-1:0] TRIG_DELAY,
    input  logic [CNT_W-1:0] CA,
    input  logic [CNT_W-1:0] CB,
    input  logic [CNT_W-1:0] CC,
    input  logic [CNT_W-1:0] CD,
    input  logic [CNT_W-1:0] CE,
    input  logic             SPI_CLK,
    input  logic             LOAD_CNT_SER,
    input  logic [2:0]       SELECT_REG,
    output logic             STOP_REQUEST,
    output logic             TRIGGERA,
    output logic             TRIGGERB,
    output logic             TRIGGERC,
    output logic             TRIGGERD,
    output logic             TRIGGERE,
    output logic             TRIGGERAC,
    output logic             TRIGGERBC,
    output logic             TRIGGERCC,
    output logic             TRIGGERDC,
    output logic             CNT_SER
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_STOPPING,
        ST_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [DLY_W-1:0]  dly_cnt_reg, dly_cnt_next;
    logic [4:0]        seg_reg, seg_next;       // one-hot: segment to fire this cycle
    logic              stop_req_reg, stop_req_next;
    logic [4:0]        trig_reg, trig_next;     // bit 0 = A ... bit 4 = E
    logic [3:0]        strobe_reg, strobe_next; // capture strobes A..D
    logic [4:0]        cap_en;

    logic [1:0]        disc_sync_reg, spi_sync_reg, load_sync_reg;
    logic              hit_prev_reg, spi_prev_reg, load_prev_reg;
    logic              hit, hit_event, stop_event, spi_fall, load_rise, load_level;

    logic [CNT_W-1:0]  cnt_in  [5];
    logic [CNT_W-1:0]  cap_reg [5];
    logic [CNT_W-1:0]  sel_word;
    logic [CNT_W-1:0]  shreg_reg;

    assign cnt_in[0] = CA;
    assign cnt_in[1] = CB;
    assign cnt_in[2] = CC;
    assign cnt_in[3] = CD;
    assign cnt_in[4] = CE;

    // Two-flop synchronisers for the asynchronous inputs plus previous-value flops for edge detection
    always_ff @(posedge FCLK) begin
        if (RST) begin
            disc_sync_reg <= '0;
            spi_sync_reg  <= '0;
            load_sync_reg <= '0;
            hit_prev_reg  <= 1'b0;
            spi_prev_reg  <= 1'b0;
            load_prev_reg <= 1'b0;
        end else begin
            disc_sync_reg <= {disc_sync_reg[0], DISCRIMINATOR_OUTPUT};
            spi_sync_reg  <= {spi_sync_reg[0], SPI_CLK};
            load_sync_reg <= {load_sync_reg[0], LOAD_CNT_SER};
            hit_prev_reg  <= hit;
            spi_prev_reg  <= spi_sync_reg[1];
            load_prev_reg <= load_sync_reg[1];
        end
    end

    assign hit        = ~(disc_sync_reg[1] ^ DISCRIMINATOR_POLARITY);
    assign hit_event  = hit & ~hit_prev_reg;
    assign stop_event = (MODE[0] & hit_event) | (MODE[1] & INST_STOP);
    assign load_level = load_sync_reg[1];
    assign load_rise  = load_level & ~load_prev_reg;
    assign spi_fall   = ~spi_sync_reg[1] & spi_prev_reg;

    // FSM and output state registers
    always_ff @(posedge FCLK) begin
        if (RST) begin
            state_reg    <= ST_IDLE;
            dly_cnt_reg  <= '0;
            seg_reg      <= '0;
            stop_req_reg <= 1'b0;
            trig_reg     <= '0;
            strobe_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            dly_cnt_reg  <= dly_cnt_next;
            seg_reg      <= seg_next;
            stop_req_reg <= stop_req_next;
            trig_reg     <= trig_next;
            strobe_reg   <= strobe_next;
        end
    end

    // Next-state logic; INST_START overrides everything else
    always_comb begin
        state_next    = state_reg;
        dly_cnt_next  = dly_cnt_reg;
        seg_next      = seg_reg;
        stop_req_next = stop_req_reg;
        trig_next     = trig_reg;
        strobe_next   = '0;
        cap_en        = '0;
        if (INST_START) begin
            state_next    = ST_ARMED;
            stop_req_next = 1'b0;
            trig_next     = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                end
                ST_ARMED: begin
                    if (stop_event) begin
                        state_next    = ST_DELAY;
                        stop_req_next = 1'b1;
                        dly_cnt_next  = '0;
                    end
                end
                ST_DELAY: begin
                    // TRIG_DELAY is compared live so it can be retuned mid-wait
                    if (dly_cnt_reg == TRIG_DELAY) begin
                        state_next = ST_STOPPING;
                        seg_next   = 5'b00001;
                    end else begin
                        dly_cnt_next = dly_cnt_reg + 1'b1;
                    end
                end
                ST_STOPPING: begin
                    trig_next   = trig_reg | seg_reg;
                    cap_en      = seg_reg;
                    strobe_next = seg_reg[3:0];
                    if (seg_reg[4]) begin
                        state_next = ST_DONE;
                    end else begin
                        seg_next = seg_reg << 1;
                    end
                end
                ST_DONE: begin
                    if (INST_READOUT) begin
                        state_next    = ST_IDLE;
                        stop_req_next = 1'b0;
                        trig_next     = '0;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Capture each coarse counter in the cycle its segment stop rises
    always_ff @(posedge FCLK) begin
        for (int i = 0; i < 5; i++) begin
            if (RST) begin
                cap_reg[i] <= '0;
            end else if (cap_en[i]) begin
                cap_reg[i] <= cnt_in[i];
            end
        end
    end

    // Readout word select; codes 5..7 give an all-zero word
    always_comb begin
        sel_word = '0;
        case (SELECT_REG)
            3'd0:    sel_word = cap_reg[0];
            3'd1:    sel_word = cap_reg[1];
            3'd2:    sel_word = cap_reg[2];
            3'd3:    sel_word = cap_reg[3];
            3'd4:    sel_word = cap_reg[4];
            default: sel_word = '0;
        endcase
    end

    // Serial shift register: load on LOAD rise, shift on SPI fall; load wins
    always_ff @(posedge FCLK) begin
        if (RST) begin
            shreg_reg <= '0;
        end else if (load_rise) begin
            shreg_reg <= sel_word;
        end else if (spi_fall && load_level) begin
            shreg_reg <= {shreg_reg[CNT_W-2:0], 1'b0};
        end
    end

    assign CNT_SER      = shreg_reg[CNT_W-1] & load_level;
    assign STOP_REQUEST = stop_req_reg;
    assign TRIGGERA     = trig_reg[0];
    assign TRIGGERB     = trig_reg[1];
    assign TRIGGERC     = trig_reg[2];
    assign TRIGGERD     = trig_reg[3];
    assign TRIGGERE     = trig_reg[4];
    assign TRIGGERAC    = strobe_reg[0];
    assign TRIGGERBC    = strobe_reg[1];
    assign TRIGGERCC    = strobe_reg[2];
    assign TRIGGERDC    = strobe_reg[3];

endmodule

// File: tb/tb_psec5_ch_digital.sv
// Testbench for psec5_ch_digital: directed steps plus randomized events,
// checked against an event-timeline model (accept cycle, delay, segment offsets).
module tb_psec5_ch_digital;

    logic       FCLK = 1'b0;
    logic       RST = 1'b1;
    logic       INST_START = 1'b0, INST_STOP = 1'b0, INST_READOUT = 1'b0;
    logic       DISCRIMINATOR_OUTPUT = 1'b0, DISCRIMINATOR_POLARITY = 1'b1;
    logic [1:0] MODE = 2'b00;
    logic [4:0] TRIG_DELAY = 5'd0;
    logic [9:0] CA = '0, CB = '0, CC = '0, CD = '0, CE = '0;
    logic       SPI_CLK = 1'b0, LOAD_CNT_SER = 1'b0;
    logic [2:0] SELECT_REG = 3'd0;
    logic       STOP_REQUEST, TRIGGERA, TRIGGERB, TRIGGERC, TRIGGERD, TRIGGERE;
    logic       TRIGGERAC, TRIGGERBC, TRIGGERCC, TRIGGERDC, CNT_SER;

    always #5 FCLK = ~FCLK;

    psec5_ch_digital #(.CNT_W(10), .DLY_W(5)) dut (
        .FCLK(FCLK), .RST(RST), .INST_START(INST_START), .INST_STOP(INST_STOP),
        .INST_READOUT(INST_READOUT), .DISCRIMINATOR_OUTPUT(DISCRIMINATOR_OUTPUT),
        .DISCRIMINATOR_POLARITY(DISCRIMINATOR_POLARITY), .MODE(MODE), .TRIG_DELAY(TRIG_DELAY),
        .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .SPI_CLK(SPI_CLK),
        .LOAD_CNT_SER(LOAD_CNT_SER), .SELECT_REG(SELECT_REG), .STOP_REQUEST(STOP_REQUEST),
        .TRIGGERA(TRIGGERA), .TRIGGERB(TRIGGERB), .TRIGGERC(TRIGGERC), .TRIGGERD(TRIGGERD),
        .TRIGGERE(TRIGGERE), .TRIGGERAC(TRIGGERAC), .TRIGGERBC(TRIGGERBC),
        .TRIGGERCC(TRIGGERCC), .TRIGGERDC(TRIGGERDC), .CNT_SER(CNT_SER)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    bit rand_c = 1'b1;

    // Reference model: an event is accepted at cycle ev_cyc; segment x fires at ev_cyc + dly + 2 + x
    bit         armed_m = 1'b0;
    bit         ev_valid_m = 1'b0;
    int         ev_cyc_m = 0;
    int         ev_dly_m = 0;
    int         hit_due_m = -1;
    logic [9:0] cap_m [5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        armed_m    = 1'b0;
        ev_valid_m = 1'b0;
        hit_due_m  = -1;
        for (int i = 0; i < 5; i++) cap_m[i] = '0;
    endtask

    // One FCLK cycle: sample inputs, clock, update model, re-randomise counters, check outputs
    task automatic step();
        logic       start_s, stop_s, rd_s, rst_s;
        logic [1:0] mode_s;
        logic [9:0] c_s [5];
        int         ta;
        logic [4:0] exp_trig;
        logic [3:0] exp_stb;
        start_s = INST_START; stop_s = INST_STOP; rd_s = INST_READOUT; rst_s = RST;
        mode_s = MODE;
        c_s[0] = CA; c_s[1] = CB; c_s[2] = CC; c_s[3] = CD; c_s[4] = CE;
        @(posedge FCLK);
        #1;
        cyc++;
        if (rst_s) begin
            model_reset();
        end else if (start_s) begin
            armed_m    = 1'b1;
            ev_valid_m = 1'b0;
        end else if (armed_m && ((mode_s[0] && cyc == hit_due_m) || (mode_s[1] && stop_s))) begin
            armed_m    = 1'b0;
            ev_valid_m = 1'b1;
            ev_cyc_m   = cyc;
            ev_dly_m   = int'(TRIG_DELAY);
        end else if (ev_valid_m && rd_s && (cyc - 1) >= ev_cyc_m + ev_dly_m + 6) begin
            ev_valid_m = 1'b0;
        end
        ta = ev_cyc_m + ev_dly_m + 2;
        if (!rst_s && !start_s && ev_valid_m) begin
            for (int x = 0; x < 5; x++) if (cyc == ta + x) cap_m[x] = c_s[x];
        end
        if (rand_c) begin
            CA = 10'($urandom); CB = 10'($urandom); CC = 10'($urandom);
            CD = 10'($urandom); CE = 10'($urandom);
        end
        for (int x = 0; x < 5; x++) exp_trig[x] = ev_valid_m && (cyc >= ta + x);
        for (int x = 0; x < 4; x++) exp_stb[x] = ev_valid_m && (cyc == ta + x);
        check("stop_request", STOP_REQUEST, ev_valid_m);
        check("trigger_a_to_e", {TRIGGERE, TRIGGERD, TRIGGERC, TRIGGERB, TRIGGERA}, exp_trig);
        check("strobe_a_to_d", {TRIGGERDC, TRIGGERCC, TRIGGERBC, TRIGGERAC}, exp_stb);
    endtask

    // Set mode/polarity safely, arm, then apply one stop stimulus (0: DISC 0->1, 1: INST_STOP)
    task automatic run_event(input int mode, input int pol, input int dly, input int src, input bit ack);
        MODE = 2'b00;
        DISCRIMINATOR_POLARITY = 1'(pol);
        DISCRIMINATOR_OUTPUT = 1'b0;
        hit_due_m = -1;
        TRIG_DELAY = 5'(dly);
        repeat (4) step();
        MODE = 2'(mode);
        INST_START = 1'b1;
        step();
        INST_START = 1'b0;
        repeat ($urandom_range(0, 3)) step();
        if (src == 0) begin
            DISCRIMINATOR_OUTPUT = 1'b1;
            if (pol != 0) hit_due_m = cyc + 3;
        end else begin
            INST_STOP = 1'b1;
        end
        step();
        INST_STOP = 1'b0;
        repeat (dly + 10) step();
        if (ack) begin
            INST_READOUT = 1'b1;
            step();
            INST_READOUT = 1'b0;
            step();
        end
    endtask

    // Serial readout of nbits bits; SELECT_REG is scrambled after the load
    task automatic read_word(input int sel, input int nbits);
        logic [9:0] w;
        w = '0;
        if (sel < 5) w = cap_m[sel];
        SELECT_REG = 3'(sel);
        LOAD_CNT_SER = 1'b1;
        repeat (5) step();
        SELECT_REG = 3'($urandom);
        for (int i = 0; i < nbits; i++) begin
            check("cnt_ser_bit", CNT_SER, w[9 - i]);
            SPI_CLK = 1'b1;
            repeat (4) step();
            SPI_CLK = 1'b0;
            repeat (4) step();
        end
        if (nbits == 10) check("cnt_ser_after_10", CNT_SER, 1'b0);
        LOAD_CNT_SER = 1'b0;
        repeat (4) step();
        check("cnt_ser_unloaded", CNT_SER, 1'b0);
    endtask

    initial begin
        model_reset();
        // Reset state
        RST = 1'b1;
        repeat (2) step();
        RST = 1'b0;
        check("cnt_ser_reset", CNT_SER, 1'b0);

        // Capture/readout: CA held at 2A5, external stop, TRIG_DELAY=5
        rand_c = 1'b0;
        CA = 10'h2A5;
        run_event(2, 1, 5, 1, 1);
        rand_c = 1'b1;
        check("cap_a_model", {22'd0, cap_m[0]}, 32'h2A5);
        read_word(0, 10);
        read_word(6, 10);

        // Polarity/mode directed cases
        run_event(1, 1, 3, 0, 1);
        run_event(1, 0, 3, 0, 0);
        run_event(0, 1, 3, 0, 0);
        run_event(0, 1, 2, 1, 0);
        run_event(3, 1, 0, 1, 1);
        read_word(4, 10);

        // INST_START together with INST_STOP: start wins, channel stays armed
        MODE = 2'b10;
        INST_START = 1'b1;
        INST_STOP = 1'b1;
        step();
        INST_START = 1'b0;
        INST_STOP = 1'b0;
        repeat (5) step();

        // Reset in the middle of STOPPING
        TRIG_DELAY = 5'd2;
        INST_STOP = 1'b1;
        step();
        INST_STOP = 1'b0;
        repeat (5) step();
        check("mid_stopping_trig_a", TRIGGERA, 1'b1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("cnt_ser_after_rst", CNT_SER, 1'b0);
        repeat (3) step();
        read_word(1, 10);

        // Randomized events and readouts
        for (int it = 0; it < 14; it++) begin
            run_event($urandom_range(0, 3), $urandom_range(0, 1),
                      (it == 3) ? 31 : ((it == 1) ? 0 : $urandom_range(0, 8)),
                      $urandom_range(0, 1), 1'b1);
            read_word($urandom_range(0, 7), (it % 3 == 0) ? $urandom_range(1, 9) : 10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
